mysystem_gpio_in: RTL and testbench

Avalon-MM slave input port: the read-side counterpart of the system's GPIO output ports. Synchronises an external `in_port` bus into the `clk` domain and exposes the live value as a readable data register. Captures per-bit edges (programmable polarity) into sticky flags and raises a maskable level interrupt toward the Nios II IRQ controller. Sits in `mysystem` next to the GPIO output ports.

---
 rtl/mysystem_gpio_in.sv | 126 ++++++++++++
 tb/tb_mysystem_gpio_in.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mysystem_gpio_in.sv
// rtl/mysystem_gpio_in.sv - Avalon-MM GPIO input port with edge capture and maskable irq.
// Optional per-bit debounce is enabled by defining GPIO_IN_DEBOUNCE_EN.
module mysystem_gpio_in #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("mysystem_gpio_in: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 1");
  end

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q, cond, cond_d_q;
  logic [WIDTH-1:0] mask_q, mask_d, pol_q, pol_d, cap_q, cap_d;
  logic [WIDTH-1:0] edge_hit, cap_clr;
  logic [1:0]       arm_q, arm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cond_d_q <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      cond_d_q <= cond;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;

  // A bit only follows sync2 after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cond = deb_q;
`else
  assign cond = sync2_q;
`endif

  assign wr_en = chipselect && !write_n;
  // Capture stays off until the synchroniser has flushed its reset zeros.
  assign armed = (arm_q == 2'd3);
  assign edge_hit = armed ? ((cond & ~cond_d_q & ~pol_q) | (~cond & cond_d_q & pol_q))
                          : '0;
  assign cap_clr = (wr_en && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    arm_d  = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    mask_d = mask_q;
    pol_d  = pol_q;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_POL)  pol_d  = writedata[WIDTH-1:0];
    cap_d = (cap_q & ~cap_clr) | edge_hit;
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = 32'(cond);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_CAP:  readdata_d = 32'(cap_q);
      ADDR_POL:  readdata_d = 32'(pol_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q      <= '0;
      mask_q     <= '0;
      pol_q      <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      arm_q      <= arm_d;
      mask_q     <= mask_d;
      pol_q      <= pol_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_mysystem_gpio_in.sv
// tb/tb_mysystem_gpio_in.sv - self-checking bench for mysystem_gpio_in.
module tb_mysystem_gpio_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  mysystem_gpio_in #(.WIDTH(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    tick();
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    v = readdata;
  endtask

  // Reference model: cond is in_port delayed by two samples, kept as a history line.
  logic [31:0] h0 = '0, h1 = '0, h2 = '0;
  logic [31:0] m_mask = '0, m_pol = '0, m_cap = '0, m_rd = '0;
  logic [31:0] m_rise, m_fall, m_set, m_clr;
  int          m_edges = 0;

  always @(posedge clk) begin
    if (reset) begin
      h0 = '0; h1 = '0; h2 = '0;
      m_mask = '0; m_pol = '0; m_cap = '0; m_rd = '0; m_edges = 0;
    end else begin
      m_rise = h1 & ~h2;
      m_fall = ~h1 & h2;
      m_set  = (m_edges >= 3) ? ((m_rise & ~m_pol) | (m_fall & m_pol)) : '0;
      case (address)
        2'd0: m_rd = h1;
        2'd1: m_rd = m_mask;
        2'd2: m_rd = m_cap;
        default: m_rd = m_pol;
      endcase
      m_clr = (chipselect && !write_n && address == 2'd2) ? writedata : '0;
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata;
      if (chipselect && !write_n && address == 2'd3) m_pol = writedata;
      m_cap = (m_cap & ~m_clr) | m_set;
      h2 = h1; h1 = h0; h0 = in_port;
      if (m_edges < 3) m_edges++;
    end
  end

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 32'h0,         32'hFFFF_FFFF, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_00FF, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0000_00FF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 32'h0,         32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0,         1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'hFFFF_FFFF, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 2'd3, 32'h0,         32'h0,         1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0,         1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0000_00FF, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_00FF, 1'b0};

    @(negedge clk);
    reset = 1'b1; in_port = 32'hFFFF_FFFF;
    repeat (3) tick();
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
`ifdef GPIO_IN_DEBOUNCE_EN
    repeat (20) tick();
    wr(2'd2, 32'hFFFF_FFFF);
`else
    repeat (10) tick();
`endif
    rd(2'd0, d); chk("idle_data", d, 32'hFFFF_FFFF);
    rd(2'd2, d); chk("idle_cap", d, 32'h0);
    chk("idle_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      chipselect = tbl[i].cs; write_n = tbl[i].wn; address = tbl[i].a; writedata = tbl[i].wd;
      tick();
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end
    write_n = 1'b1;

`ifdef GPIO_IN_DEBOUNCE_EN
    reset = 1'b1; in_port = '0; tick(); reset = 1'b0;
    repeat (20) tick();
    in_port = 32'h1; repeat (3) tick(); in_port = 32'h0;
    repeat (20) tick();
    rd(2'd0, d); chk("deb_glitch_data", d, 32'h0);
    rd(2'd2, d); chk("deb_glitch_cap", d, 32'h0);
    in_port = 32'h1; repeat (6) tick(); in_port = 32'h0;
    repeat (20) tick();
    rd(2'd2, d); chk("deb_pulse_cap", d, 32'h1);
    rd(2'd0, d); chk("deb_pulse_data", d, 32'h0);
`else
    // Rising capture on bit 0 with exact latency
    wr(2'd1, 32'h1);
    in_port = 32'hFFFF_FFFE; repeat (5) tick();
    in_port = 32'hFFFF_FFFF; address = 2'd2; chipselect = 1'b1; write_n = 1'b1;
    tick(); chk("rise_irq_e0", {31'b0, irq}, 32'h0);
    tick(); chk("rise_irq_e1", {31'b0, irq}, 32'h0);
    tick(); chk("rise_irq_e2", {31'b0, irq}, 32'h1);
    tick(); chk("rise_cap_read", readdata, 32'h1);
    wr(2'd2, 32'h1); chk("clr_irq", {31'b0, irq}, 32'h0);
    rd(2'd2, d); chk("clr_cap", d, 32'h0);

    // Falling polarity and masking
    wr(2'd3, 32'h4); wr(2'd1, 32'h0);
    in_port = 32'hFFFF_FFFB; repeat (4) tick();
    rd(2'd2, d); chk("fall_cap", d, 32'h4);
    chk("fall_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h4); chk("fall_irq_unmasked", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h4); chk("fall_clr_irq", {31'b0, irq}, 32'h0);
    in_port = 32'hFFFF_FFFF; repeat (4) tick();
    rd(2'd2, d); chk("fall_rise_ignored", d, 32'h0);

    // Clear and set colliding on bit 3
    wr(2'd3, 32'h0);
    in_port = 32'hFFFF_FFF7; repeat (4) tick();
    in_port = 32'hFFFF_FFFF; tick(); tick();
    wr(2'd2, 32'h8);
    rd(2'd2, d); chk("collide_set_wins", d, 32'h8);

    // Reset mid-operation, then arming window
    wr(2'd1, 32'hF0);
    in_port = 32'hFFFF_FF0F; repeat (4) tick();
    in_port = 32'hFFFF_FFFF; repeat (4) tick();
    wr(2'd2, 32'h8);
    rd(2'd2, d); chk("pre_reset_cap", d, 32'hF0);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    in_port = 32'hFFFF_FF00; reset = 1'b1; tick();
    chk("mid_reset_irq", {31'b0, irq}, 32'h0);
    chk("mid_reset_rd", readdata, 32'h0);
    reset = 1'b0; in_port = 32'hFFFF_FFFF;
    repeat (10) tick();
    rd(2'd2, d); chk("arm_window_cap", d, 32'h0);
    rd(2'd1, d); chk("post_reset_mask", d, 32'h0);
    rd(2'd3, d); chk("post_reset_pol", d, 32'h0);
    rd(2'd0, d); chk("post_reset_data", d, 32'hFFFF_FFFF);

    // First live edge: input change sampled on the 2nd edge after release
    in_port = 32'hFFFF_FFFE; reset = 1'b1; tick();
    reset = 1'b0; tick();
    in_port = 32'hFFFF_FFFF;
    repeat (6) tick();
    rd(2'd2, d); chk("arm_first_live", d, 32'h1);

    // Randomised traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      address    = 2'($urandom_range(0, 3));
      chipselect = $urandom_range(0, 3) != 0;
      write_n    = $urandom_range(0, 2) != 0;
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ ($urandom & $urandom & $urandom);
      tick();
      chk("rand_readdata", readdata, m_rd);
      chk("rand_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
